// File: rtl/lf_adder_pipe.sv
// Pipelined Ladner-Fischer adder/subtractor with valid/ready handshake on both sides.
// Prefix levels are spread over NSTG register stages; the last stage registers sum and flags.
module lf_adder_pipe #(
  parameter int WIDTH = 64,
  parameter int NSTG  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int L  = $clog2(WIDTH);
  localparam int BW = 3 * WIDTH + 1;  // {cin, bitwise p, group G, group P}

  function automatic int lvl_lo(input int j);
    int r;
    if (NSTG == 1) begin
      r = (j == 0) ? 0 : L;
    end else if (j >= NSTG - 1) begin
      r = L;
    end else begin
      r = (j * L + NSTG - 2) / (NSTG - 1);
    end
    return r;
  endfunction

  function automatic logic [BW-1:0] lf_level(input logic [BW-1:0] x, input int k);
    logic [WIDTH-1:0] g_v, p_v, g_n, p_n;
    int               j;
    g_v = x[2*WIDTH-1:WIDTH];
    p_v = x[WIDTH-1:0];
    g_n = g_v;
    p_n = p_v;
    for (int i = 0; i < WIDTH; i++) begin
      if (((i >> k) & 1) != 0) begin
        j      = (i | ((1 << k) - 1)) - (1 << k);
        g_n[i] = g_v[i] | (p_v[i] & g_v[j]);
        p_n[i] = p_v[i] & p_v[j];
      end else begin
        g_n[i] = g_v[i];
        p_n[i] = p_v[i];
      end
    end
    return {x[BW-1:2*WIDTH], g_n, p_n};
  endfunction

  logic [NSTG-1:0]  v_r;
  logic [NSTG-1:0]  ld_s;
  logic [NSTG-1:0]  vin_s;
  logic [BW-1:0]    x_s [NSTG];
  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH-1:0] pb_s;
  logic [WIDTH-1:0] g_s;
  logic [WIDTH-1:0] s_r;
  logic             cout_r;
  logic             ovf_r;
  logic             zero_r;

  assign b_eff_s = b ^ {WIDTH{sub}};
  assign pb_s    = a ^ b_eff_s;
  assign g_s     = a & b_eff_s;
  assign x_s[0]  = {cin, pb_s, g_s, pb_s};

  // A stage may load when it or any later stage is empty, or the output is draining.
  always_comb begin
    ld_s  = {NSTG{1'b0}};
    vin_s = {NSTG{1'b0}};
    for (int j = 0; j < NSTG; j++) begin
      ld_s[j] = out_ready;
      for (int k = j; k < NSTG; k++) begin
        ld_s[j] = ld_s[j] | ~v_r[k];
      end
      vin_s[j] = (j == 0) ? in_valid : v_r[j-1];
    end
  end

  // Valid bits move one stage forward whenever the receiving stage can load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_r <= {NSTG{1'b0}};
    end else begin
      for (int j = 0; j < NSTG; j++) begin
        if (ld_s[j]) begin
          v_r[j] <= vin_s[j];
        end else begin
          v_r[j] <= v_r[j];
        end
      end
    end
  end

  for (genvar j = 0; j < NSTG; j++) begin : g_stg
    localparam int LO = lvl_lo(j);
    localparam int HI = lvl_lo(j + 1);
    logic [BW-1:0] q_s;

    // Prefix levels that belong to this stage.
    always_comb begin
      q_s = x_s[j];
      for (int k = LO; k < HI; k++) begin
        q_s = lf_level(q_s, k);
      end
    end

    if (j < NSTG - 1) begin : g_reg
      logic [BW-1:0] d_r;

      // Stage data only captures real beats; an empty stage's contents are irrelevant.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          d_r <= {BW{1'b0}};
        end else if (ld_s[j] && vin_s[j]) begin
          d_r <= q_s;
        end else begin
          d_r <= d_r;
        end
      end

      assign x_s[j+1] = d_r;
    end else begin : g_out
      logic [WIDTH:0]   c_s;
      logic [WIDTH-1:0] sum_s;

      // Carries from the finished prefix with cin folded in, then the sum bits.
      always_comb begin
        c_s    = {(WIDTH + 1){1'b0}};
        c_s[0] = q_s[BW-1];
        for (int i = 0; i < WIDTH; i++) begin
          c_s[i+1] = q_s[WIDTH+i] | (q_s[i] & q_s[BW-1]);
        end
        sum_s = q_s[3*WIDTH-1:2*WIDTH] ^ c_s[WIDTH-1:0];
      end

      // Result register holds its last valid beat through stalls and idle cycles.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s_r    <= {WIDTH{1'b0}};
          cout_r <= 1'b0;
          ovf_r  <= 1'b0;
          zero_r <= 1'b0;
        end else if (ld_s[j] && vin_s[j]) begin
          s_r    <= sum_s;
          cout_r <= c_s[WIDTH];
          ovf_r  <= c_s[WIDTH-1] ^ c_s[WIDTH];
          zero_r <= ~|sum_s;
        end else begin
          s_r    <= s_r;
          cout_r <= cout_r;
          ovf_r  <= ovf_r;
          zero_r <= zero_r;
        end
      end
    end
  end

  assign in_ready  = ld_s[0];
  assign out_valid = v_r[NSTG-1];
  assign s         = s_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;
  assign zero      = zero_r;

endmodule

// File: tb/tb_lf_adder_pipe.sv
// Bench for lf_adder_pipe: directed cases on three configurations plus a scoreboarded
// random stream with backpressure on the 64-bit, 3-stage instance.
module tb_lf_adder_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         out_ready;
  logic         iv;
  logic         cin_w;
  logic         sub_w;
  logic [127:0] a_w;
  logic [127:0] b_w;
  int           sel;
  int           checks = 0;
  int           errors = 0;

  logic iv0, iv1, iv2;
  assign iv0 = iv && (sel == 0);
  assign iv1 = iv && (sel == 1);
  assign iv2 = iv && (sel == 2);

  logic          ir0, ov0, co0, of0, z0;
  logic [63:0]   s0;
  logic          ir1, ov1, co1, of1, z1;
  logic [7:0]    s1;
  logic          ir2, ov2, co2, of2, z2;
  logic [127:0]  s2;

  lf_adder_pipe #(.WIDTH(64), .NSTG(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0),
    .a(a_w[63:0]), .b(b_w[63:0]), .cin(cin_w), .sub(sub_w),
    .out_valid(ov0), .out_ready(out_ready), .s(s0), .cout(co0), .ovf(of0), .zero(z0));

  lf_adder_pipe #(.WIDTH(8), .NSTG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
    .a(a_w[7:0]), .b(b_w[7:0]), .cin(cin_w), .sub(sub_w),
    .out_valid(ov1), .out_ready(out_ready), .s(s1), .cout(co1), .ovf(of1), .zero(z1));

  lf_adder_pipe #(.WIDTH(128), .NSTG(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
    .a(a_w), .b(b_w), .cin(cin_w), .sub(sub_w),
    .out_valid(ov2), .out_ready(out_ready), .s(s2), .cout(co2), .ovf(of2), .zero(z2));

  logic         ir_m, ov_m;
  logic [127:0] s_m;
  logic [2:0]   fl_m;

  always_comb begin
    case (sel)
      1: begin ir_m = ir1; ov_m = ov1; s_m = {120'd0, s1}; fl_m = {z1, of1, co1}; end
      2: begin ir_m = ir2; ov_m = ov2; s_m = s2; fl_m = {z2, of2, co2}; end
      default: begin ir_m = ir0; ov_m = ov0; s_m = {64'd0, s0}; fl_m = {z0, of0, co0}; end
    endcase
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide addition; returns {zero, ovf, cout, s}.
  function automatic logic [66:0] model64(input logic [63:0] ma, input logic [63:0] mb,
                                          input logic mc, input logic ms);
    logic [63:0] be;
    logic [64:0] full;
    logic        ov;
    be   = ms ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, be} + {64'd0, mc};
    ov   = (ma[63] == be[63]) && (full[63] != ma[63]);
    return {(full[63:0] == 64'd0), ov, full[64], full[63:0]};
  endfunction

  // Scoreboard and protocol monitor for the 64-bit instance.
  logic [66:0] sbq [$];
  int          emitted = 0;
  logic        held_v = 1'b0;
  logic [67:0] held_o;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      sbq.delete();
      held_v = 1'b0;
    end else begin
      if (held_v) chk("stall_hold", 128'({ov0, z0, of0, co0, s0}), 128'(held_o));
      chk("in_ready", 128'(ir0), 128'(!(sbq.size() == 3 && !out_ready)));
      if (sbq.size() == 0) chk("idle_valid", 128'(ov0), 128'(1'b0));
      if (ov0 && out_ready && sbq.size() != 0) begin
        chk("result", 128'({z0, of0, co0, s0}), 128'(sbq.pop_front()));
        emitted++;
      end
      if (iv0 && ir0) sbq.push_back(model64(a_w[63:0], b_w[63:0], cin_w, sub_w));
      held_v = ov0 && !out_ready;
      held_o = {ov0, z0, of0, co0, s0};
    end
  end

  task automatic directed(input int dsel, input logic [127:0] ta, input logic [127:0] tb2,
                          input logic tc, input logic ts, input logic [127:0] es,
                          input logic [2:0] efl, input int elat, input string tag);
    int lat;
    sel = dsel;
    out_ready = 1'b1;
    a_w = ta; b_w = tb2; cin_w = tc; sub_w = ts; iv = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 128'(ir_m), 128'(1'b1));
    @(posedge clk); #1;
    iv = 1'b0;
    lat = 1;
    while (ov_m !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 128'(lat), 128'(elat));
    chk({tag, "_sum"}, s_m, es);
    chk({tag, "_flags"}, 128'(fl_m), 128'(efl));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int   sent;
    int   guard;
    int   base;
    logic took;

    rst_n = 1'b0; out_ready = 1'b1; iv = 1'b0; sel = 0;
    a_w = 128'd0; b_w = 128'd0; cin_w = 1'b0; sub_w = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset_out0", 128'({ov0, z0, of0, co0, s0}), 128'd0);
    chk("reset_in_ready0", 128'(ir0), 128'(1'b1));
    chk("reset_valid12", 128'({ov1, ov2}), 128'd0);

    directed(0, 128'd15, 128'd10, 1'b0, 1'b0, 128'd25, 3'b000, 3, "w64_add");
    directed(0, 128'hFFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0, 1'b0, 128'd0, 3'b101, 3, "w64_wrap");
    directed(0, 128'hFFFF_FFFF_FFFF_FFFF, 128'd1, 1'b1, 1'b0, 128'd1, 3'b001, 3, "w64_wrap_cin");
    directed(0, 128'h7FFF_FFFF_FFFF_FFFF, 128'd1, 1'b0, 1'b0,
             128'h8000_0000_0000_0000, 3'b010, 3, "w64_ovf");
    directed(0, 128'd5, 128'd7, 1'b1, 1'b1, 128'hFFFF_FFFF_FFFF_FFFE, 3'b000, 3, "w64_sub");

    directed(1, 128'd15, 128'd10, 1'b0, 1'b0, 128'd25, 3'b000, 1, "w8_add");
    directed(1, 128'hFF, 128'h01, 1'b0, 1'b0, 128'h00, 3'b101, 1, "w8_wrap");
    directed(1, 128'h80, 128'h01, 1'b1, 1'b1, 128'h7F, 3'b011, 1, "w8_sub_ovf");

    directed(2, 128'd15, 128'd10, 1'b0, 1'b0, 128'd25, 3'b000, 8, "w128_add");
    directed(2, {128{1'b1}}, 128'd1, 1'b0, 1'b0, 128'd0, 3'b101, 8, "w128_wrap");
    directed(2, {1'b0, {127{1'b1}}}, 128'd1, 1'b0, 1'b0, {1'b1, 127'd0}, 3'b010, 8, "w128_ovf");
    directed(2, 128'd5, 128'd7, 1'b1, 1'b1, {{127{1'b1}}, 1'b0}, 3'b000, 8, "w128_sub");

    // Random stream with backpressure on the 64-bit instance.
    sel = 0; base = emitted; sent = 0; guard = 0;
    while (sent < 100 && guard < 3000) begin
      out_ready = ($urandom_range(0, 9) >= 3);
      if (!iv) begin
        a_w   = {64'd0, $urandom(), $urandom()};
        b_w   = {64'd0, $urandom(), $urandom()};
        cin_w = 1'($urandom_range(0, 1));
        sub_w = 1'($urandom_range(0, 1));
        iv    = 1'b1;
      end
      @(negedge clk);
      took = ir0;
      @(posedge clk); #1;
      if (took) begin
        sent++;
        iv = 1'b0;
      end
      guard++;
    end
    iv = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (sbq.size() != 0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("stream_sent", 128'(sent), 128'd100);
    chk("stream_drained", 128'(sbq.size()), 128'd0);
    chk("stream_count", 128'(emitted - base), 128'd100);

    // Fill under backpressure, then reset with beats in flight.
    out_ready = 1'b0;
    b_w = 128'd3; cin_w = 1'b0; sub_w = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_w = 128'(i + 1);
      iv = 1'b1;
      @(negedge clk);
      if (i == 3) chk("fourth_refused", 128'(ir0), 128'(1'b0));
      @(posedge clk); #1;
    end
    chk("full_valid", 128'(ov0), 128'(1'b1));
    iv = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midreset_valid", 128'(ov0), 128'(1'b0));
    chk("midreset_sum", 128'(s0), 128'd0);
    chk("midreset_in_ready", 128'(ir0), 128'(1'b1));
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("no_stale_beat", 128'(ov0), 128'(1'b0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
